// File: rtl/rx_arb_if.sv
// Bundle between the RX PHY channels, the arbiter and the RX FIFO write port.
// master: the arbiter (drives pops and FIFO writes).
// slave : the channel/FIFO side (drives requests, show-ahead data, almost-full).
// Handshake: a channel holds ch_req high while it has an unread complete report
// and presents its current word on ch_dat; a high ch_rd bit in a cycle pops that
// word and the channel shows the next word from the following cycle. rx_vld is a
// write strobe with no back-pressure; room is guaranteed up front by checking
// rx_almost_full before a report is admitted.
interface rx_arb_if #(
  parameter int PHY_NUM = 32
);
  logic [PHY_NUM-1:0]    ch_req;
  logic [32*PHY_NUM-1:0] ch_dat;
  logic [PHY_NUM-1:0]    ch_rd;
  logic                  rx_almost_full;
  logic                  rx_vld;
  logic [31:0]           rx_dat;

  modport master (
    input  ch_req, ch_dat, rx_almost_full,
    output ch_rd, rx_vld, rx_dat
  );

  modport slave (
    output ch_req, ch_dat, rx_almost_full,
    input  ch_rd, rx_vld, rx_dat
  );
endinterface

// File: rtl/rx_arb.sv
// Round-robin scheduler sharing the single RX FIFO write port between the RX PHY
// channels. A report (header word plus RPT_LEN payload words) is admitted only
// when the FIFO has room for all of it, so reports are never split.
module rx_arb #(
  parameter int PHY_NUM = 32,
  parameter int RPT_LEN = 8,
  parameter int IDX_W   = 5
) (
  input  logic               clk,
  input  logic               rst,
  rx_arb_if.master           bus,
  input  logic [PHY_NUM-1:0] reg_mask_i,
  output logic [PHY_NUM-1:0] grant_o,
  output logic               busy_o,
  output logic [15:0]        seq_o,
  output logic               err_o,
  output logic [1:0]         state_o
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HDR  = 2'd1,
    XFER = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t             state_q;
  logic [IDX_W-1:0]   ptr_q;
  logic [PHY_NUM-1:0] grant_q;
  logic               rx_vld_q;
  logic [31:0]        rx_dat_q;
  logic [7:0]         cnt_q;
  logic [15:0]        seq_q;
  logic               err_q;

  logic [PHY_NUM-1:0] eligible;
  logic [IDX_W-1:0]   ptr_d;
  logic [IDX_W:0]     cand;
  logic [PHY_NUM-1:0] grant_d;
  logic [31:0]        sel_dat;
  logic               req_ok;
  logic [4:0]         hdr_idx;

  // Winner search: scan ptr+PHY_NUM down to ptr+1 so the nearest eligible
  // channel after the last winner is the one left in ptr_d.
  always_comb begin
    eligible = bus.ch_req & ~reg_mask_i;
    ptr_d    = ptr_q;
    cand     = '0;
    for (int k = PHY_NUM; k >= 1; k--) begin
      cand = {1'b0, ptr_q} + (IDX_W+1)'(k);
      if (cand >= (IDX_W+1)'(PHY_NUM)) begin
        cand = cand - (IDX_W+1)'(PHY_NUM);
      end
      if (eligible[cand[IDX_W-1:0]]) begin
        ptr_d = cand[IDX_W-1:0];
      end
    end
    grant_d = PHY_NUM'(1) << ptr_d;
  end

  // Data mux of the granted channel plus its request level for error tracking.
  always_comb begin
    sel_dat = '0;
    for (int i = 0; i < PHY_NUM; i++) begin
      if (grant_q[i]) begin
        sel_dat = sel_dat | bus.ch_dat[32*i +: 32];
      end
    end
    req_ok  = |(bus.ch_req & grant_q);
    hdr_idx = 5'(ptr_q);
  end

  // Report FSM: IDLE arbitrates, HDR writes the header, XFER drains the
  // payload, DONE closes the report and bumps the sequence number.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      ptr_q    <= IDX_W'(PHY_NUM-1);
      grant_q  <= '0;
      rx_vld_q <= 1'b0;
      rx_dat_q <= '0;
      cnt_q    <= '0;
      seq_q    <= '0;
      err_q    <= 1'b0;
    end else begin
      rx_vld_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if ((|eligible) && !bus.rx_almost_full) begin
            state_q <= HDR;
            grant_q <= grant_d;
            ptr_q   <= ptr_d;
          end
        end
        HDR: begin
          rx_vld_q <= 1'b1;
          rx_dat_q <= {8'hA5, 3'b000, hdr_idx, seq_q};
          cnt_q    <= '0;
          state_q  <= XFER;
        end
        XFER: begin
          rx_vld_q <= 1'b1;
          rx_dat_q <= sel_dat;
          cnt_q    <= cnt_q + 8'd1;
          if (!req_ok) begin
            err_q <= 1'b1;
          end
          if (cnt_q == 8'(RPT_LEN-1)) begin
            state_q <= DONE;
          end
        end
        DONE: begin
          grant_q <= '0;
          seq_q   <= seq_q + 16'd1;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // The pop strobe follows the grant only while payload is being drained.
  assign bus.ch_rd  = (state_q == XFER) ? grant_q : '0;
  assign bus.rx_vld = rx_vld_q;
  assign bus.rx_dat = rx_dat_q;
  assign grant_o    = grant_q;
  assign busy_o     = (state_q != IDLE);
  assign seq_o      = seq_q;
  assign err_o      = err_q;
  assign state_o    = state_q;

endmodule

// File: tb/tb_rx_arb.sv
// Bench for rx_arb: table of single-edge arbitration vectors from reset, then
// hand-written multi-cycle sequences (single report, round-robin, mask,
// back-pressure, reset mid-report, protocol error).
module tb_rx_arb;
  localparam int PHY_NUM = 32;
  localparam int RPT_LEN = 8;
  localparam int IDX_W   = 5;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [PHY_NUM-1:0] reg_mask = '0;
  logic [PHY_NUM-1:0] grant;
  logic               busy;
  logic [15:0]        seq;
  logic               err;
  logic [1:0]         state;

  rx_arb_if #(.PHY_NUM(PHY_NUM)) bus ();

  rx_arb #(.PHY_NUM(PHY_NUM), .RPT_LEN(RPT_LEN), .IDX_W(IDX_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus),
    .reg_mask_i (reg_mask),
    .grant_o    (grant),
    .busy_o     (busy),
    .seq_o      (seq),
    .err_o      (err),
    .state_o    (state)
  );

  // ---------------- channel model ----------------
  function automatic logic [31:0] dat_word(input int ch, input int unsigned n);
    return 32'h0000_0100 + n + (32'(ch) << 16);
  endfunction

  logic        k_clr = 1'b0;
  int unsigned k [PHY_NUM];

  always @(posedge clk) begin
    for (int i = 0; i < PHY_NUM; i++) begin
      if (k_clr) k[i] <= 0;
      else if (bus.ch_rd[i]) k[i] <= k[i] + 1;
    end
  end

  always_comb begin
    for (int i = 0; i < PHY_NUM; i++) begin
      bus.ch_dat[32*i +: 32] = dat_word(i, k[i]);
    end
  end

  // ---------------- monitor ----------------
  logic [31:0] got_q[$];
  int          pops [PHY_NUM];
  int          rd_bad = 0;

  always @(negedge clk) begin
    if (bus.rx_vld) got_q.push_back(bus.rx_dat);
    if (!$onehot0(bus.ch_rd) || ((bus.ch_rd & ~grant) != '0)) rd_bad++;
    for (int i = 0; i < PHY_NUM; i++) begin
      if (k_clr) pops[i] = 0;
      else if (bus.ch_rd[i]) pops[i]++;
    end
  end

  // ---------------- scoreboard ----------------
  logic [31:0] exp_q[$];
  int          exp_k [PHY_NUM];
  int          rd_ptr = 0;
  int          errors = 0;
  int          checks = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] hdr_word(input int ch, input int s);
    return {8'hA5, 3'b000, 5'(ch), 16'(s)};
  endfunction

  task automatic push_report(input int ch, input int s);
    exp_q.push_back(hdr_word(ch, s));
    for (int j = 0; j < RPT_LEN; j++) begin
      exp_q.push_back(dat_word(ch, exp_k[ch]));
      exp_k[ch]++;
    end
  endtask

  task automatic drain_check(input string name);
    logic [31:0] e;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      if (rd_ptr < got_q.size()) begin
        check(name, 64'(got_q[rd_ptr]), 64'(e));
        rd_ptr++;
      end else begin
        check({name, "_missing"}, 64'(0), 64'(e));
      end
    end
    check({name, "_extra"}, 64'(got_q.size() - rd_ptr), 64'(0));
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst   = 1'b1;
    k_clr = 1'b1;
    tick();
    rst   = 1'b0;
    k_clr = 1'b0;
    exp_q.delete();
    rd_ptr = got_q.size();
    for (int i = 0; i < PHY_NUM; i++) exp_k[i] = 0;
  endtask

  task automatic wait_pops(input int ch, input int target, input string name);
    for (int c = 0; c < 300 && pops[ch] < target; c++) tick();
    check(name, 64'(pops[ch] >= target), 64'(1));
  endtask

  task automatic wait_idle(input string name);
    for (int c = 0; c < 100 && busy; c++) tick();
    check(name, 64'(busy), 64'(0));
  endtask

  // ---------------- arbitration vector table ----------------
  typedef struct {
    logic [PHY_NUM-1:0] req;
    logic [PHY_NUM-1:0] mask;
    logic               af;
    logic [PHY_NUM-1:0] exp_grant;
  } vec_t;

  vec_t vecs [9];

  // ---------------- test sequence ----------------
  initial begin
    int rr_ch [5];
    int busy_seen;

    bus.ch_req         = '0;
    bus.rx_almost_full = 1'b0;

    vecs[0] = '{req: 32'h0000_0008, mask: 32'h0,         af: 1'b0, exp_grant: 32'h0000_0008};
    vecs[1] = '{req: 32'h8000_0001, mask: 32'h0,         af: 1'b0, exp_grant: 32'h0000_0001};
    vecs[2] = '{req: 32'h0000_00A0, mask: 32'h0000_0020, af: 1'b0, exp_grant: 32'h0000_0080};
    vecs[3] = '{req: 32'h0000_0021, mask: 32'h0000_0021, af: 1'b0, exp_grant: 32'h0};
    vecs[4] = '{req: 32'h0000_0004, mask: 32'h0,         af: 1'b1, exp_grant: 32'h0};
    vecs[5] = '{req: 32'h8000_0000, mask: 32'h0,         af: 1'b0, exp_grant: 32'h8000_0000};
    vecs[6] = '{req: 32'h0,         mask: 32'h0,         af: 1'b0, exp_grant: 32'h0};
    vecs[7] = '{req: 32'hFFFF_FFFF, mask: 32'hFFFF_FFFE, af: 1'b0, exp_grant: 32'h0000_0001};
    vecs[8] = '{req: 32'hFFFF_FFFF, mask: 32'h7FFF_FFFF, af: 1'b0, exp_grant: 32'h8000_0000};

    // Reset state
    do_reset();
    check("rst_rx_vld", 64'(bus.rx_vld), 64'(0));
    check("rst_rx_dat", 64'(bus.rx_dat), 64'(0));
    check("rst_grant",  64'(grant),      64'(0));
    check("rst_busy",   64'(busy),       64'(0));
    check("rst_seq",    64'(seq),        64'(0));
    check("rst_err",    64'(err),        64'(0));
    check("rst_ch_rd",  64'(bus.ch_rd),  64'(0));

    // Table: one IDLE edge after reset, then reset kills the report.
    for (int v = 0; v < 9; v++) begin
      do_reset();
      bus.ch_req         = vecs[v].req;
      reg_mask           = vecs[v].mask;
      bus.rx_almost_full = vecs[v].af;
      tick();
      check("arb_grant", 64'(grant), 64'(vecs[v].exp_grant));
      check("arb_busy",  64'(busy),  64'(vecs[v].exp_grant != '0));
      bus.ch_req         = '0;
      reg_mask           = '0;
      bus.rx_almost_full = 1'b0;
      do_reset();
      check("arb_abort_vld", 64'(got_q.size() - rd_ptr), 64'(0));
    end

    // Single report on channel 3 with header latency
    do_reset();
    push_report(3, 0);
    bus.ch_req = 32'h0000_0008;
    tick();
    check("single_lat_vld0", 64'(bus.rx_vld), 64'(0));
    check("single_grant",    64'(grant),      64'(32'h8));
    tick();
    check("single_hdr_vld",  64'(bus.rx_vld), 64'(1));
    check("single_hdr_dat",  64'(bus.rx_dat), 64'(32'hA503_0000));
    wait_pops(3, 8, "single_pops_reached");
    bus.ch_req = '0;
    wait_idle("single_idle");
    tick();
    check("single_pops",  64'(pops[3]), 64'(8));
    check("single_seq",   64'(seq),     64'(1));
    check("single_grant0", 64'(grant),  64'(0));
    drain_check("single_word");

    // Round-robin fairness over channels 0, 5, 31
    do_reset();
    rr_ch = '{0, 5, 31, 0, 5};
    bus.ch_req = 32'h8000_0021;
    for (int r = 0; r < 5; r++) begin
      push_report(rr_ch[r], r);
      wait_pops(rr_ch[r], exp_k[rr_ch[r]], "rr_pops_reached");
    end
    bus.ch_req = '0;
    wait_idle("rr_idle");
    check("rr_seq", 64'(seq), 64'(5));
    drain_check("rr_word");

    // Mask channels 0 and 5
    do_reset();
    reg_mask   = 32'h0000_0021;
    bus.ch_req = 32'h0000_00A1;
    push_report(7, 0);
    wait_pops(7, 8, "mask_pops_reached");
    bus.ch_req = 32'h0000_0021;
    repeat (20) tick();
    check("mask_busy",  64'(busy),    64'(0));
    check("mask_pops0", 64'(pops[0]), 64'(0));
    check("mask_pops5", 64'(pops[5]), 64'(0));
    check("mask_seq",   64'(seq),     64'(1));
    drain_check("mask_word");
    bus.ch_req = '0;
    reg_mask   = '0;

    // Back-pressure
    do_reset();
    bus.rx_almost_full = 1'b1;
    bus.ch_req         = 32'h0000_0004;
    busy_seen = 0;
    repeat (50) begin
      tick();
      if (busy) busy_seen++;
    end
    check("bp_no_grant", 64'(busy_seen), 64'(0));
    check("bp_no_vld",   64'(got_q.size() - rd_ptr), 64'(0));
    bus.rx_almost_full = 1'b0;
    push_report(2, 0);
    tick();
    check("bp_lat_vld0", 64'(bus.rx_vld), 64'(0));
    tick();
    check("bp_hdr_vld",  64'(bus.rx_vld), 64'(1));
    check("bp_hdr_dat",  64'(bus.rx_dat), 64'(32'hA502_0000));
    tick();
    tick();
    bus.rx_almost_full = 1'b1;
    wait_pops(2, 8, "bp_pops_reached");
    bus.ch_req = '0;
    wait_idle("bp_idle");
    drain_check("bp_word");
    bus.rx_almost_full = 1'b0;

    // Reset in the 4th XFER cycle of a report on channel 4
    do_reset();
    bus.ch_req = 32'h0000_0010;
    exp_q.push_back(hdr_word(4, 0));
    for (int j = 0; j < 3; j++) exp_q.push_back(dat_word(4, j));
    wait_pops(4, 3, "rstx_pops_reached");
    rst        = 1'b1;
    bus.ch_req = '0;
    tick();
    rst = 1'b0;
    check("rstx_vld",   64'(bus.rx_vld), 64'(0));
    check("rstx_grant", 64'(grant),      64'(0));
    check("rstx_seq",   64'(seq),        64'(0));
    check("rstx_busy",  64'(busy),       64'(0));
    repeat (5) tick();
    drain_check("rstx_word");
    bus.ch_req = 32'h0000_0021;
    tick();
    check("rstx_prio0", 64'(grant), 64'(32'h1));
    bus.ch_req = '0;
    do_reset();

    // Protocol error: channel 1 drops its request mid-report
    push_report(1, 0);
    bus.ch_req = 32'h0000_0002;
    wait_pops(1, 2, "err_pops_reached");
    check("err_before", 64'(err), 64'(0));
    bus.ch_req = '0;
    tick();
    check("err_set", 64'(err), 64'(1));
    wait_pops(1, 8, "err_pops_done");
    wait_idle("err_idle");
    repeat (10) tick();
    check("err_pops",   64'(pops[1]), 64'(8));
    check("err_sticky", 64'(err),     64'(1));
    drain_check("err_word");
    do_reset();
    check("err_cleared", 64'(err), 64'(0));

    check("ch_rd_onehot_in_grant", 64'(rd_bad), 64'(0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Global time limit
  initial begin
    #500000;
    $display("FAIL timeout: got no completion expected completion");
    $fatal(1, "time limit reached");
  end

endmodule
